alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter DEC_EN, default 1, meaning decimal-mode sequencing is enabled (0 forces enable_dec low).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req_valid, input, 1 bit: an operation request is present.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-006 The block SHALL have port req_op, input, 3 bits: 0 ADC, 1 SBC, 2 AND, 3 EOR, 4 ORA, 5 LSR, 6 ROR, 7 CMP.
REQ-007 The block SHALL have ports req_a and req_m, inputs, 8 bits each: accumulator-side operand and memory-side operand.
REQ-008 The block SHALL have ports req_c, req_v and req_d, inputs, 1 bit each: incoming carry, overflow and decimal flags.
REQ-009 The block SHALL have ports sb_out and db_out, outputs, 8 bits each: ALU A-side and B-side data.
REQ-010 The block SHALL have 1-bit outputs ldb_inv_db, ldb_db, ldb_adl, lda_sb, lda_zero, enable_dec, carry_in, e_sum, e_and, e_eor, e_or and e_shiftr: the ALU control lines.
REQ-011 The block SHALL have ports alu_out (8 bits), alu_carry and alu_overflow (1 bit each), inputs: the ALU results.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit, and port rsp_ready, input, 1 bit: the response handshake.
REQ-013 The block SHALL have port rsp_result, output, 8 bits: the operation result.
REQ-014 The block SHALL have 1-bit outputs rsp_n, rsp_z, rsp_c, rsp_v and rsp_wr: the result flags and the register-writeback enable.

Function
REQ-015 The FSM SHALL have states IDLE, EXEC and DONE; req_ready=1 only in IDLE; rsp_valid=1 only in DONE.
REQ-016 IDLE->EXEC on req_valid&&req_ready; op, operands and flags SHALL be latched at that edge.
REQ-017 EXEC SHALL last exactly one cycle and drive the ALU controls from the latched values; the edge ending EXEC SHALL capture alu_out, alu_carry and alu_overflow, then go to DONE.
REQ-018 DONE->IDLE on rsp_ready; rsp_* SHALL be held stable while rsp_valid&&!rsp_ready.
REQ-019 Latency SHALL be: request accepted at edge N, rsp_valid high from edge N+2; minimum issue interval 3 cycles.
REQ-020 Outside EXEC all ALU control outputs, sb_out and db_out SHALL be 0; ldb_adl and lda_zero SHALL always be 0.
REQ-021 In EXEC: lda_sb=1 and sb_out=latched A for every op; db_out=latched M.
REQ-022 ADC: ldb_db=1, e_sum=1, carry_in=C.
REQ-023 SBC: ldb_inv_db=1, e_sum=1, carry_in=C.
REQ-024 CMP: ldb_inv_db=1, e_sum=1, carry_in=1, enable_dec=0.
REQ-025 AND/EOR/ORA: ldb_db=1 with e_and, e_eor or e_or respectively; carry_in=0.
REQ-026 LSR: e_shiftr=1, carry_in=0; ROR: e_shiftr=1, carry_in=C; no B-side load.
REQ-027 enable_dec SHALL be D&&DEC_EN for ADC/SBC only, otherwise 0.
REQ-028 Exactly one e_* line and at most one ldb_* line SHALL be high in any cycle.
REQ-029 rsp_result SHALL equal the captured alu_out; rsp_n=result[7]; rsp_z=(result==0).
REQ-030 rsp_c SHALL be the captured alu_carry for ADC, SBC, CMP, LSR and ROR, and the latched C for AND, EOR and ORA.
REQ-031 rsp_v SHALL be the captured alu_overflow for ADC and SBC, and the latched V otherwise.
REQ-032 rsp_wr SHALL be 1 for all ops except CMP, which SHALL give rsp_wr=0.
REQ-033 req_valid outside IDLE SHALL be ignored (not latched, no state change); a request changing while not accepted has no effect.
REQ-034 A request arriving in the same cycle as DONE&&rsp_ready SHALL NOT be accepted until the following IDLE cycle.

Reset
REQ-035 On rst=1 at a clock edge the FSM SHALL go to IDLE, all latched and captured registers SHALL clear to 0, and all outputs SHALL be 0 except req_ready=1 in the following cycle.
REQ-036 Reset in EXEC or DONE SHALL abort the operation with no response; rst SHALL take priority over all handshakes.

Verification (bench pairs the block with the team ALU)
REQ-037 ADC, A=0x50, M=0x50, C=0, D=0 -> result 0xA0, N=1, Z=0, C=0, V=alu_overflow (1), wr=1, at edge N+2.
REQ-038 SBC, A=0x05, M=0x03, C=1 -> ldb_inv_db and e_sum high in EXEC; result 0x02, C=1, Z=0, wr=1.
REQ-039 CMP, A=0x10, M=0x20, C=0 -> carry_in=1 in EXEC; result 0xF0, N=1, Z=0, C=0, wr=0, V=latched V.
REQ-040 ROR, A=0x01, C=1 -> e_shiftr with carry_in=1; result 0x80, C=1, N=1; LSR of 0x01 -> 0x00, Z=1, C=1.
REQ-041 AND, A=0xF0, M=0x0F, C=1 with rsp_ready held low 3 cycles -> result 0x00, Z=1, C=1; rsp_* stable; req_valid pulses during DONE ignored.
REQ-042 rst asserted in EXEC -> next cycle IDLE, rsp_valid=0, all ALU controls 0, req_ready=1, and no response issued.

Source files
------------

// File: rtl/alu_sequencer.sv
// Request/response sequencer for an 8-bit accumulator ALU: latches an operation,
// drives the ALU control lines for one cycle, and returns the result with flags.
module alu_sequencer #(
    parameter int DEC_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_a,
    input  logic [7:0] req_m,
    input  logic       req_c,
    input  logic       req_v,
    input  logic       req_d,
    output logic [7:0] sb_out,
    output logic [7:0] db_out,
    output logic       ldb_inv_db,
    output logic       ldb_db,
    output logic       ldb_adl,
    output logic       lda_sb,
    output logic       lda_zero,
    output logic       enable_dec,
    output logic       carry_in,
    output logic       e_sum,
    output logic       e_and,
    output logic       e_eor,
    output logic       e_or,
    output logic       e_shiftr,
    input  logic [7:0] alu_out,
    input  logic       alu_carry,
    input  logic       alu_overflow,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_result,
    output logic       rsp_n,
    output logic       rsp_z,
    output logic       rsp_c,
    output logic       rsp_v,
    output logic       rsp_wr
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [2:0] OP_ADC = 3'd0;
    localparam logic [2:0] OP_SBC = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_EOR = 3'd3;
    localparam logic [2:0] OP_ORA = 3'd4;
    localparam logic [2:0] OP_LSR = 3'd5;
    localparam logic [2:0] OP_ROR = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    state_t     state_r;
    state_t     state_next_s;
    logic       accept_s;
    logic       capture_s;

    logic [2:0] op_r;
    logic       c_r;
    logic       v_r;
    // Control bus layout: {inv_db, db, sb, dec, cin, sum, and, eor, or, shiftr}
    logic [9:0] ctrl_r;
    logic [7:0] sb_r;
    logic [7:0] db_r;

    logic [7:0] result_r;
    logic       n_r;
    logic       z_r;
    logic       cf_r;
    logic       vf_r;
    logic       wr_r;

    function automatic logic [9:0] decode_ctrl(input logic [2:0] op,
                                               input logic       c,
                                               input logic       d);
        logic dec_s;
        dec_s = d && (DEC_EN != 0);
        case (op)
            OP_ADC:  decode_ctrl = {1'b0, 1'b1, 1'b1, dec_s, c,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            OP_SBC:  decode_ctrl = {1'b1, 1'b0, 1'b1, dec_s, c,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            OP_AND:  decode_ctrl = {1'b0, 1'b1, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            OP_EOR:  decode_ctrl = {1'b0, 1'b1, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            OP_ORA:  decode_ctrl = {1'b0, 1'b1, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            OP_LSR:  decode_ctrl = {1'b0, 1'b0, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            OP_ROR:  decode_ctrl = {1'b0, 1'b0, 1'b1, 1'b0,  c,    1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            OP_CMP:  decode_ctrl = {1'b1, 1'b0, 1'b1, 1'b0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            default: decode_ctrl = 10'b0;
        endcase
    endfunction

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic plus the accept/capture strobes for the datapath
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        capture_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_next_s = EXEC;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            EXEC: begin
                state_next_s = DONE;
                capture_s    = 1'b1;
            end
            DONE: begin
                if (rsp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Request latch, registered ALU controls and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r     <= 3'd0;
            c_r      <= 1'b0;
            v_r      <= 1'b0;
            ctrl_r   <= 10'd0;
            sb_r     <= 8'd0;
            db_r     <= 8'd0;
            result_r <= 8'd0;
            n_r      <= 1'b0;
            z_r      <= 1'b0;
            cf_r     <= 1'b0;
            vf_r     <= 1'b0;
            wr_r     <= 1'b0;
        end else if (accept_s) begin
            op_r   <= req_op;
            c_r    <= req_c;
            v_r    <= req_v;
            ctrl_r <= decode_ctrl(req_op, req_c, req_d);
            sb_r   <= req_a;
            db_r   <= req_m;
        end else if (capture_s) begin
            // Controls drop as EXEC ends so they are only ever high during EXEC
            ctrl_r   <= 10'd0;
            sb_r     <= 8'd0;
            db_r     <= 8'd0;
            result_r <= alu_out;
            n_r      <= alu_out[7];
            z_r      <= (alu_out == 8'd0);
            cf_r     <= ((op_r == OP_AND) || (op_r == OP_EOR) || (op_r == OP_ORA)) ? c_r : alu_carry;
            vf_r     <= ((op_r == OP_ADC) || (op_r == OP_SBC)) ? alu_overflow : v_r;
            wr_r     <= (op_r != OP_CMP);
        end else begin
            ctrl_r <= ctrl_r;
        end
    end

    assign req_ready  = (state_r == IDLE);
    assign rsp_valid  = (state_r == DONE);

    assign ldb_inv_db = ctrl_r[9];
    assign ldb_db     = ctrl_r[8];
    assign lda_sb     = ctrl_r[7];
    assign enable_dec = ctrl_r[6];
    assign carry_in   = ctrl_r[5];
    assign e_sum      = ctrl_r[4];
    assign e_and      = ctrl_r[3];
    assign e_eor      = ctrl_r[2];
    assign e_or       = ctrl_r[1];
    assign e_shiftr   = ctrl_r[0];
    assign ldb_adl    = 1'b0;
    assign lda_zero   = 1'b0;
    assign sb_out     = sb_r;
    assign db_out     = db_r;

    assign rsp_result = result_r;
    assign rsp_n      = n_r;
    assign rsp_z      = z_r;
    assign rsp_c      = cf_r;
    assign rsp_v      = vf_r;
    assign rsp_wr     = wr_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer paired with a small behavioural ALU.
module tb_alu_sequencer;

    logic       clk;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_m;
    logic       req_c;
    logic       req_v;
    logic       req_d;
    logic [7:0] sb_out;
    logic [7:0] db_out;
    logic       ldb_inv_db, ldb_db, ldb_adl, lda_sb, lda_zero, enable_dec, carry_in;
    logic       e_sum, e_and, e_eor, e_or, e_shiftr;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic       alu_overflow;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_n, rsp_z, rsp_c, rsp_v, rsp_wr;

    int vec_cnt;
    int err_cnt;

    alu_sequencer #(.DEC_EN(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_m(req_m), .req_c(req_c), .req_v(req_v), .req_d(req_d),
        .sb_out(sb_out), .db_out(db_out),
        .ldb_inv_db(ldb_inv_db), .ldb_db(ldb_db), .ldb_adl(ldb_adl), .lda_sb(lda_sb),
        .lda_zero(lda_zero), .enable_dec(enable_dec), .carry_in(carry_in),
        .e_sum(e_sum), .e_and(e_and), .e_eor(e_eor), .e_or(e_or), .e_shiftr(e_shiftr),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_n(rsp_n), .rsp_z(rsp_z), .rsp_c(rsp_c), .rsp_v(rsp_v), .rsp_wr(rsp_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU (binary arithmetic only)
    logic [7:0] alu_a_s, alu_b_s;
    logic [8:0] sum_s;
    always_comb begin
        alu_a_s      = lda_sb ? sb_out : 8'h00;
        alu_b_s      = ldb_db ? db_out : (ldb_inv_db ? ~db_out : 8'h00);
        sum_s        = {1'b0, alu_a_s} + {1'b0, alu_b_s} + {8'h00, carry_in};
        alu_out      = 8'h00;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        if (e_sum) begin
            alu_out      = sum_s[7:0];
            alu_carry    = sum_s[8];
            alu_overflow = (alu_a_s[7] == alu_b_s[7]) && (sum_s[7] != alu_a_s[7]);
        end else if (e_and) begin
            alu_out = alu_a_s & alu_b_s;
        end else if (e_eor) begin
            alu_out = alu_a_s ^ alu_b_s;
        end else if (e_or) begin
            alu_out = alu_a_s | alu_b_s;
        end else if (e_shiftr) begin
            alu_out   = {carry_in, alu_a_s[7:1]};
            alu_carry = alu_a_s[0];
        end else begin
            alu_out = 8'h00;
        end
    end

    // {inv_db, db, sb, dec, cin, sum, and, eor, or, shiftr, adl, zero}
    wire [11:0] ctrl_w = {ldb_inv_db, ldb_db, lda_sb, enable_dec, carry_in,
                          e_sum, e_and, e_eor, e_or, e_shiftr, ldb_adl, lda_zero};
    wire [4:0]  flags_w = {rsp_n, rsp_z, rsp_c, rsp_v, rsp_wr};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [2:0] op, input logic [7:0] a, input logic [7:0] m,
                             input logic c, input logic v, input logic d);
        req_op    = op;
        req_a     = a;
        req_m     = m;
        req_c     = c;
        req_v     = v;
        req_d     = d;
        req_valid = 1'b1;
    endtask

    // One full transaction; hold = cycles rsp_ready stays low in DONE
    task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] m, input logic c, input logic v, input logic d,
                         input logic [11:0] exp_ctrl, input logic [7:0] exp_res,
                         input logic [4:0] exp_flags, input int hold);
        drive_req(op, a, m, c, v, d);
        tick();
        req_valid = 1'b0;
        check({tag, ".exec_ready"}, {31'd0, req_ready}, 32'd0);
        check({tag, ".exec_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, ".exec_ctrl"}, {20'd0, ctrl_w}, {20'd0, exp_ctrl});
        check({tag, ".exec_sb"}, {24'd0, sb_out}, {24'd0, a});
        check({tag, ".exec_db"}, {24'd0, db_out}, {24'd0, m});
        tick();
        check({tag, ".done_valid"}, {31'd0, rsp_valid}, 32'd1);
        check({tag, ".result"}, {24'd0, rsp_result}, {24'd0, exp_res});
        check({tag, ".flags"}, {27'd0, flags_w}, {27'd0, exp_flags});
        check({tag, ".done_ctrl"}, {20'd0, ctrl_w}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            drive_req(3'd0, ~a, ~m, ~c, ~v, 1'b0);
            tick();
            req_valid = 1'b0;
            check({tag, ".hold_valid"}, {31'd0, rsp_valid}, 32'd1);
            check({tag, ".hold_ready"}, {31'd0, req_ready}, 32'd0);
            check({tag, ".hold_result"}, {24'd0, rsp_result}, {24'd0, exp_res});
            check({tag, ".hold_flags"}, {27'd0, flags_w}, {27'd0, exp_flags});
            check({tag, ".hold_ctrl"}, {20'd0, ctrl_w}, 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, ".idle_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, ".idle_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        vec_cnt   = 0;
        err_cnt   = 0;
        rst       = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_op    = 3'd0;
        req_a     = 8'h00;
        req_m     = 8'h00;
        req_c     = 1'b0;
        req_v     = 1'b0;
        req_d     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst.ready", {31'd0, req_ready}, 32'd1);
        check("rst.valid", {31'd0, rsp_valid}, 32'd0);
        check("rst.ctrl", {20'd0, ctrl_w}, 32'd0);
        check("rst.sb_db", {16'd0, sb_out, db_out}, 32'd0);
        check("rst.rsp", {19'd0, rsp_result, flags_w}, 32'd0);

        // flags order: {N, Z, C, V, wr}
        do_op("adc", 3'd0, 8'h50, 8'h50, 1'b0, 1'b0, 1'b0,
              12'b0110_0100_0000, 8'hA0, 5'b10011, 0);
        do_op("adc_dec", 3'd0, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1,
              12'b0111_0100_0000, 8'h02, 5'b00001, 0);
        do_op("sbc", 3'd1, 8'h05, 8'h03, 1'b1, 1'b1, 1'b0,
              12'b1010_1100_0000, 8'h02, 5'b00101, 0);
        do_op("cmp", 3'd7, 8'h10, 8'h20, 1'b0, 1'b1, 1'b1,
              12'b1010_1100_0000, 8'hF0, 5'b10010, 0);
        do_op("ror", 3'd6, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0,
              12'b0010_1000_0100, 8'h80, 5'b10101, 0);
        do_op("lsr", 3'd5, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0,
              12'b0010_0000_0100, 8'h00, 5'b01101, 0);
        do_op("eor", 3'd3, 8'hFF, 8'h0F, 1'b0, 1'b1, 1'b0,
              12'b0110_0001_0000, 8'hF0, 5'b10011, 0);
        do_op("ora", 3'd4, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0,
              12'b0110_0000_1000, 8'h00, 5'b01101, 0);
        do_op("cmp2", 3'd7, 8'h10, 8'h20, 1'b0, 1'b1, 1'b0,
              12'b1010_1100_0000, 8'hF0, 5'b10010, 0);
        do_op("and_hold", 3'd2, 8'hF0, 8'h0F, 1'b1, 1'b0, 1'b0,
              12'b0110_0010_0000, 8'h00, 5'b01101, 3);

        // Request arriving with DONE&&rsp_ready waits for the next IDLE cycle
        drive_req(3'd4, 8'h81, 8'h02, 1'b0, 1'b0, 1'b0);
        tick();
        req_valid = 1'b0;
        tick();
        check("b2b.done", {31'd0, rsp_valid}, 32'd1);
        check("b2b.res", {24'd0, rsp_result}, 32'h83);
        drive_req(3'd0, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("b2b.not_taken", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        check("b2b.taken", {31'd0, req_ready}, 32'd0);
        check("b2b.sb", {24'd0, sb_out}, 32'h11);
        tick();
        check("b2b.res2", {24'd0, rsp_result}, 32'h33);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset during EXEC aborts the operation
        drive_req(3'd0, 8'h40, 8'h01, 1'b0, 1'b0, 1'b0);
        tick();
        req_valid = 1'b0;
        check("rexec.in_exec", {31'd0, e_sum}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rexec.ready", {31'd0, req_ready}, 32'd1);
        check("rexec.valid", {31'd0, rsp_valid}, 32'd0);
        check("rexec.ctrl", {20'd0, ctrl_w}, 32'd0);
        check("rexec.sb_db", {16'd0, sb_out, db_out}, 32'd0);
        check("rexec.rsp", {19'd0, rsp_result, flags_w}, 32'd0);
        tick();
        tick();
        check("rexec.no_rsp", {31'd0, rsp_valid}, 32'd0);
        do_op("post_rst", 3'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0,
              12'b0110_0100_0000, 8'h00, 5'b01101, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
